fht_but_feeder: RTL and testbench

- Operand/address sequencer on the input side of fht_but: drives one radix-2 Hartley butterfly per clock through all log2(N) stages of an N-point FHT.
- Generates read addresses for x0/x1/x2, the twiddle (sin/cos) ROM address, and the matching write-back addresses for y0/y1, delayed by the memory-plus-butterfly pipeline.
- Uses ping-pong data banks; bit-reversed loading and unloading are handled outside this block.

---
 rtl/fht_but_feeder.sv | 183 ++++++++++++++++++
 tb/tb_fht_but_feeder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fht_but_feeder.sv
// Operand/address sequencer for the fht_but radix-2 Hartley butterfly.
// Walks every stage of an N-point FHT, one butterfly per clock, and delays the write-back addresses to match the pipeline.
module fht_but_feeder #(
    parameter int unsigned N_LOG2  = 4,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned BUT_LAT = 1
) (
    input  logic                                                iCLK,
    input  logic                                                iRESET,
    input  logic                                                iSTART,
    output logic                                                oRD_EN,
    output logic [N_LOG2-1:0]                                   oRD_ADDR_0,
    output logic [N_LOG2-1:0]                                   oRD_ADDR_1,
    output logic [N_LOG2-1:0]                                   oRD_ADDR_2,
    output logic [N_LOG2-2:0]                                   oTW_ADDR,
    output logic                                                oWR_EN,
    output logic [N_LOG2-1:0]                                   oWR_ADDR_0,
    output logic [N_LOG2-1:0]                                   oWR_ADDR_1,
    output logic                                                oBANK,
    output logic [((N_LOG2 > 1) ? $clog2(N_LOG2) : 1)-1:0]      oSTAGE,
    output logic                                                oBUSY,
    output logic                                                oDONE
);

    localparam int unsigned D      = RD_LAT + BUT_LAT;
    localparam int unsigned CW     = N_LOG2 - 1;
    localparam int unsigned HALF_N = 1 << (N_LOG2 - 1);
    localparam int unsigned SW     = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
    localparam int unsigned DW     = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned TWW    = 2 * N_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     s, s_nxt;
    logic [CW-1:0]     c, c_nxt;
    logic [DW-1:0]     dcnt, dcnt_nxt;

    logic [N_LOG2-1:0] cx, half, k, b;
    logic [N_LOG2-1:0] a0_nxt, a1_nxt, a2_nxt;
    logic [TWW-1:0]    tw_wide;
    logic [CW-1:0]     tw_nxt;
    logic              rd_en_nxt, busy_nxt, done_nxt;

    logic              wr_en_q [0:D-1];
    logic [N_LOG2-1:0] wr_a0_q [0:D-1];
    logic [N_LOG2-1:0] wr_a1_q [0:D-1];

    // State and counter registers
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state <= IDLE;
            s     <= '0;
            c     <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            c     <= c_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    // Next-state logic; outputs are registered from the next-state view so they align with the state
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        c_nxt     = c;
        dcnt_nxt  = dcnt;
        case (state)
            IDLE: begin
                if (iSTART) begin
                    state_nxt = RUN;
                    s_nxt     = '0;
                    c_nxt     = '0;
                end
            end
            RUN: begin
                if (c == CW'(HALF_N - 1)) begin
                    state_nxt = DRAIN;
                    dcnt_nxt  = '0;
                end else begin
                    c_nxt = c + CW'(1);
                end
            end
            DRAIN: begin
                if (dcnt == DW'(D - 1)) begin
                    if (s == SW'(N_LOG2 - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                        s_nxt     = s + SW'(1);
                        c_nxt     = '0;
                    end
                end else begin
                    dcnt_nxt = dcnt + DW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                s_nxt     = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Butterfly address arithmetic for the issue slot about to be presented
    always_comb begin
        cx      = N_LOG2'(c_nxt);
        half    = N_LOG2'(1) << s_nxt;
        k       = cx & (half - N_LOG2'(1));
        b       = ((cx >> s_nxt) << 1) << s_nxt;
        tw_wide = (TWW'(k) << (N_LOG2 - 1)) >> s_nxt;
        a0_nxt  = '0;
        a1_nxt  = '0;
        a2_nxt  = '0;
        tw_nxt  = '0;
        if (state_nxt == RUN) begin
            a0_nxt = b + k;
            a1_nxt = b + half + k;
            a2_nxt = b + half + ((half - k) & (half - N_LOG2'(1)));
            tw_nxt = CW'(tw_wide);
        end
        rd_en_nxt = (state_nxt == RUN);
        busy_nxt  = (state_nxt == RUN) || (state_nxt == DRAIN);
        done_nxt  = (state_nxt == DONE);
    end

    // Registered read-side outputs
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            oRD_EN     <= 1'b0;
            oRD_ADDR_0 <= '0;
            oRD_ADDR_1 <= '0;
            oRD_ADDR_2 <= '0;
            oTW_ADDR   <= '0;
            oBANK      <= 1'b0;
            oSTAGE     <= '0;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
        end else begin
            oRD_EN     <= rd_en_nxt;
            oRD_ADDR_0 <= a0_nxt;
            oRD_ADDR_1 <= a1_nxt;
            oRD_ADDR_2 <= a2_nxt;
            oTW_ADDR   <= tw_nxt;
            oBANK      <= s_nxt[0];
            oSTAGE     <= s_nxt;
            oBUSY      <= busy_nxt;
            oDONE      <= done_nxt;
        end
    end

    // Write-back delay line; idle read slots carry zero addresses so idle write slots do too
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            for (int unsigned i = 0; i < D; i++) begin
                wr_en_q[i] <= 1'b0;
                wr_a0_q[i] <= '0;
                wr_a1_q[i] <= '0;
            end
        end else begin
            wr_en_q[0] <= oRD_EN;
            wr_a0_q[0] <= oRD_ADDR_0;
            wr_a1_q[0] <= oRD_ADDR_1;
            for (int unsigned i = 1; i < D; i++) begin
                wr_en_q[i] <= wr_en_q[i-1];
                wr_a0_q[i] <= wr_a0_q[i-1];
                wr_a1_q[i] <= wr_a1_q[i-1];
            end
        end
    end

    assign oWR_EN     = wr_en_q[D-1];
    assign oWR_ADDR_0 = wr_a0_q[D-1];
    assign oWR_ADDR_1 = wr_a1_q[D-1];

endmodule

// File: tb/tb_fht_but_feeder.sv
// Bench for fht_but_feeder: two 8-point instances (latency 2 and 4) checked against a scoreboard of expected reads, writes and done pulses.
module tb_fht_but_feeder;

    localparam int NL = 3;
    localparam int NH = 4;

    typedef struct {
        int cyc;
        int a0;
        int a1;
        int a2;
        int tw;
        int s;
    } rd_t;

    typedef struct {
        int cyc;
        int a0;
        int a1;
    } wr_t;

    logic       clk;
    logic       rst      [2];
    logic       start    [2];
    logic       rd_en    [2];
    logic [2:0] ra0      [2];
    logic [2:0] ra1      [2];
    logic [2:0] ra2      [2];
    logic [1:0] tw       [2];
    logic       wr_en    [2];
    logic [2:0] wa0      [2];
    logic [2:0] wa1      [2];
    logic       bank     [2];
    logic [1:0] stage    [2];
    logic       busy     [2];
    logic       done     [2];

    rd_t rdq [2][$];
    wr_t wrq [2][$];
    int  dq  [2][$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    fht_but_feeder #(.N_LOG2(3), .RD_LAT(1), .BUT_LAT(1)) u0 (
        .iCLK(clk), .iRESET(rst[0]), .iSTART(start[0]),
        .oRD_EN(rd_en[0]), .oRD_ADDR_0(ra0[0]), .oRD_ADDR_1(ra1[0]), .oRD_ADDR_2(ra2[0]),
        .oTW_ADDR(tw[0]), .oWR_EN(wr_en[0]), .oWR_ADDR_0(wa0[0]), .oWR_ADDR_1(wa1[0]),
        .oBANK(bank[0]), .oSTAGE(stage[0]), .oBUSY(busy[0]), .oDONE(done[0])
    );

    fht_but_feeder #(.N_LOG2(3), .RD_LAT(1), .BUT_LAT(3)) u1 (
        .iCLK(clk), .iRESET(rst[1]), .iSTART(start[1]),
        .oRD_EN(rd_en[1]), .oRD_ADDR_0(ra0[1]), .oRD_ADDR_1(ra1[1]), .oRD_ADDR_2(ra2[1]),
        .oTW_ADDR(tw[1]), .oWR_EN(wr_en[1]), .oWR_ADDR_0(wa0[1]), .oWR_ADDR_1(wa1[1]),
        .oBANK(bank[1]), .oSTAGE(stage[1]), .oBUSY(busy[1]), .oDONE(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dlat(int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int busy_len(int i);
        return NL * (NH + dlat(i));
    endfunction

    // Per-cycle scoreboard monitor, one per instance
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        rd_t er;
        wr_t ew;
        bit  exp_busy;
        always @(negedge clk) begin
            if (mon_on) begin
                exp_busy = (dq[gi].size() > 0) && (cyc >= dq[gi][0] - busy_len(gi)) && (cyc < dq[gi][0]);
                total++;
                if (busy[gi] !== exp_busy) begin
                    bad++;
                    $display("FAIL busy u%0d cyc=%0d got=%b exp=%b", gi, cyc, busy[gi], exp_busy);
                end
                if (rdq[gi].size() > 0 && rdq[gi][0].cyc < cyc) begin
                    total++; bad++;
                    $display("FAIL rd_missing u%0d cyc=%0d exp_issue_cyc=%0d", gi, cyc, rdq[gi][0].cyc);
                    void'(rdq[gi].pop_front());
                end
                if (wrq[gi].size() > 0 && wrq[gi][0].cyc < cyc) begin
                    total++; bad++;
                    $display("FAIL wr_missing u%0d cyc=%0d exp_write_cyc=%0d", gi, cyc, wrq[gi][0].cyc);
                    void'(wrq[gi].pop_front());
                end
                if (dq[gi].size() > 0 && dq[gi][0] < cyc) begin
                    total++; bad++;
                    $display("FAIL done_missing u%0d cyc=%0d exp_done_cyc=%0d", gi, cyc, dq[gi][0]);
                    void'(dq[gi].pop_front());
                end
                if (rd_en[gi] !== 1'b0) begin
                    total++;
                    if (rdq[gi].size() == 0) begin
                        bad++;
                        $display("FAIL rd_unexpected u%0d cyc=%0d rd_en=%b", gi, cyc, rd_en[gi]);
                    end else begin
                        er = rdq[gi].pop_front();
                        if (er.cyc != cyc || ra0[gi] !== 3'(er.a0) || ra1[gi] !== 3'(er.a1) ||
                            ra2[gi] !== 3'(er.a2) || tw[gi] !== 2'(er.tw) ||
                            stage[gi] !== 2'(er.s) || bank[gi] !== 1'(er.s & 1)) begin
                            bad++;
                            $display("FAIL rd_issue u%0d cyc=%0d got=(%0d,%0d,%0d) tw=%0d s=%0d bank=%b exp@%0d=(%0d,%0d,%0d) tw=%0d s=%0d",
                                     gi, cyc, ra0[gi], ra1[gi], ra2[gi], tw[gi], stage[gi], bank[gi],
                                     er.cyc, er.a0, er.a1, er.a2, er.tw, er.s);
                        end
                    end
                end
                total++;
                if (wr_en[gi] !== 1'b0) begin
                    if (wrq[gi].size() == 0) begin
                        bad++;
                        $display("FAIL wr_unexpected u%0d cyc=%0d wr_en=%b", gi, cyc, wr_en[gi]);
                    end else begin
                        ew = wrq[gi].pop_front();
                        if (ew.cyc != cyc || wa0[gi] !== 3'(ew.a0) || wa1[gi] !== 3'(ew.a1)) begin
                            bad++;
                            $display("FAIL wr_pair u%0d cyc=%0d got=(%0d,%0d) exp@%0d=(%0d,%0d)",
                                     gi, cyc, wa0[gi], wa1[gi], ew.cyc, ew.a0, ew.a1);
                        end
                    end
                end else if (wa0[gi] !== 3'd0 || wa1[gi] !== 3'd0) begin
                    bad++;
                    $display("FAIL wr_idle_addr u%0d cyc=%0d got=(%0d,%0d) exp=(0,0)", gi, cyc, wa0[gi], wa1[gi]);
                end
                if (done[gi] !== 1'b0) begin
                    total++;
                    if (dq[gi].size() == 0 || dq[gi][0] != cyc) begin
                        bad++;
                        $display("FAIL done_pulse u%0d cyc=%0d done=%b exp_cyc=%0d", gi, cyc, done[gi],
                                 (dq[gi].size() > 0) ? dq[gi][0] : -1);
                    end
                    if (dq[gi].size() > 0) void'(dq[gi].pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected transform: stage s, group g, butterfly offset kk within group
    task automatic push_run(input int i, input int t);
        rd_t r;
        wr_t w;
        int  d;
        int  half;
        d = dlat(i);
        for (int s = 0; s < NL; s++) begin
            half = 1 << s;
            for (int g = 0; g < (2 * NH) / (2 * half); g++) begin
                for (int kk = 0; kk < half; kk++) begin
                    r.cyc = t + 1 + s * (NH + d) + g * half + kk;
                    r.a0  = g * 2 * half + kk;
                    r.a1  = g * 2 * half + half + kk;
                    r.a2  = g * 2 * half + half + ((half - kk) % half);
                    r.tw  = kk * ((2 * NH) / (2 * half));
                    r.s   = s;
                    rdq[i].push_back(r);
                    w.cyc = r.cyc + d;
                    w.a0  = r.a0;
                    w.a1  = r.a1;
                    wrq[i].push_back(w);
                end
            end
        end
        dq[i].push_back(t + 1 + NL * (NH + d));
    endtask

    task automatic flush(input int i);
        rdq[i].delete();
        wrq[i].delete();
        dq[i].delete();
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        while ((rdq[i].size() > 0 || wrq[i].size() > 0 || dq[i].size() > 0) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL drain_timeout u%0d pending rd=%0d wr=%0d done=%0d", i, rdq[i].size(), wrq[i].size(), dq[i].size());
            flush(i);
        end
        tick();
        tick();
    endtask

    task automatic check_all_zero(input int i, input string tag);
        @(negedge clk);
        total++;
        if ({rd_en[i], ra0[i], ra1[i], ra2[i], tw[i], wr_en[i], wa0[i], wa1[i], bank[i], stage[i], busy[i], done[i]} !== 25'd0) begin
            bad++;
            $display("FAIL %s u%0d cyc=%0d outputs=%h exp=0", tag, i, cyc,
                     {rd_en[i], ra0[i], ra1[i], ra2[i], tw[i], wr_en[i], wa0[i], wa1[i], bank[i], stage[i], busy[i], done[i]});
        end
    endtask

    task automatic test_reset();
        rst[0] = 1'b1; rst[1] = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        tick();
        tick();
        rst[0] = 1'b0; rst[1] = 1'b0;
        mon_on = 1'b1;
        for (int n = 0; n < 10; n++) begin
            check_all_zero(0, "reset_idle");
            check_all_zero(1, "reset_idle");
            tick();
        end
    endtask

    task automatic test_stage_run();
        int t;
        t = cyc;
        start[0] = 1'b1;
        push_run(0, t);
        tick();
        start[0] = 1'b0;
        @(negedge clk);
        total++;
        if (rd_en[0] !== 1'b1 || ra0[0] !== 3'd0 || ra1[0] !== 3'd1 || ra2[0] !== 3'd1 || bank[0] !== 1'b0) begin
            bad++;
            $display("FAIL first_issue cyc=%0d got en=%b (%0d,%0d,%0d) bank=%b exp en=1 (0,1,1) bank=0",
                     cyc, rd_en[0], ra0[0], ra1[0], ra2[0], bank[0]);
        end
        wait_idle(0, 60);
        check_all_zero(0, "after_run");
    endtask

    task automatic test_back_to_back();
        int t;
        t = cyc;
        start[0] = 1'b1;
        push_run(0, t);
        tick();
        start[0] = 1'b0;
        while (cyc < t + 5) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        while (cyc < t + 19) tick();
        start[0] = 1'b1;
        tick();
        push_run(0, t + 20);
        tick();
        start[0] = 1'b0;
        wait_idle(0, 80);
    endtask

    task automatic test_mid_reset();
        int t;
        t = cyc;
        start[0] = 1'b1;
        push_run(0, t);
        tick();
        start[0] = 1'b0;
        while (cyc < t + 8) tick();
        rst[0] = 1'b1;
        tick();
        flush(0);
        rst[0] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check_all_zero(0, "mid_reset");
            tick();
        end
        t = cyc;
        start[0] = 1'b1;
        push_run(0, t);
        tick();
        start[0] = 1'b0;
        @(negedge clk);
        total++;
        if (rd_en[0] !== 1'b1 || ra0[0] !== 3'd0 || ra1[0] !== 3'd1 || ra2[0] !== 3'd1 || stage[0] !== 2'd0) begin
            bad++;
            $display("FAIL restart_issue cyc=%0d got en=%b (%0d,%0d,%0d) s=%0d exp en=1 (0,1,1) s=0",
                     cyc, rd_en[0], ra0[0], ra1[0], ra2[0], stage[0]);
        end
        wait_idle(0, 60);
    endtask

    task automatic test_long_latency();
        int t;
        t = cyc;
        start[1] = 1'b1;
        push_run(1, t);
        tick();
        start[1] = 1'b0;
        while (cyc < t + 25) tick();
        @(negedge clk);
        total++;
        if (done[1] !== 1'b1 || busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL long_done cyc=%0d got done=%b busy=%b exp done=1 busy=0", cyc, done[1], busy[1]);
        end
        wait_idle(1, 60);
    endtask

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        test_reset();
        test_stage_run();
        test_back_to_back();
        test_mid_reset();
        test_long_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d exp=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
